// File: rtl/instr_align_buffer_pkg.sv
// Shared widths and constants for the IF/ID instruction alignment buffer.
package instr_align_buffer_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned INSTR_WIDTH = 64;
    localparam int unsigned HW_WIDTH    = 16;
    localparam int unsigned WORD_HW     = INSTR_WIDTH / HW_WIDTH;

    localparam logic [31:0]            NOP_INSTR  = 32'h0000_0013;
    localparam logic [INSTR_WIDTH-1:0] NOP_WINDOW = {NOP_INSTR, NOP_INSTR};

endpackage

// File: rtl/hw_ring_buffer.sv
// Halfword ring: 4-halfword write with leading skip, 4-halfword wrapped read window, consume.
module hw_ring_buffer
    import instr_align_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_HW = 16,
    localparam int unsigned PtrW    = $clog2(DEPTH_HW),
    localparam int unsigned CntW    = PtrW + 1
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   wrEn,
    input  logic [INSTR_WIDTH-1:0] wrData,
    input  logic [1:0]             wrSkip,
    input  logic [2:0]             consume,
    output logic [CntW-1:0]        count,
    output logic [INSTR_WIDTH-1:0] window
);

    logic [HW_WIDTH-1:0] mem [DEPTH_HW];
    logic [PtrW-1:0]     headQ;
    logic [CntW-1:0]     countQ;
    logic [PtrW-1:0]     tailPtr;
    logic [2:0]          wrCnt;

    assign tailPtr = headQ + countQ[PtrW-1:0];
    assign wrCnt   = wrEn ? (3'd4 - {1'b0, wrSkip}) : 3'd0;
    assign count   = countQ;

    // Halfwords below the skip offset are dropped; the rest pack contiguously at the tail.
    always_ff @(posedge clk) begin
        if (wrEn && !clear) begin
            for (int k = 0; k < WORD_HW; k++) begin
                if (k >= int'(wrSkip)) begin
                    mem[tailPtr + PtrW'(k - int'(wrSkip))] <= wrData[k*HW_WIDTH +: HW_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            headQ  <= '0;
            countQ <= '0;
        end else begin
            headQ  <= headQ + PtrW'(consume);
            countQ <= countQ + CntW'(wrCnt) - CntW'(consume);
        end
    end

    always_comb begin
        window = '0;
        for (int k = 0; k < WORD_HW; k++) begin
            window[k*HW_WIDTH +: HW_WIDTH] = mem[headQ + PtrW'(k)];
        end
    end

endmodule

// File: rtl/instr_align_buffer.sv
// Fetch front end: sequential 8-byte requests into a halfword ring, aligned 64-bit window to Decode.
module instr_align_buffer
    import instr_align_buffer_pkg::*;
#(
    parameter int unsigned           DEPTH_HW  = 16,
    parameter int unsigned           MAX_OUTST = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  flush_pc,
    output logic                   fetch_req_valid,
    input  logic                   fetch_req_ready,
    output logic [ADDR_WIDTH-1:0]  fetch_addr,
    input  logic                   resp_valid,
    input  logic [INSTR_WIDTH-1:0] resp_data,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    input  logic                   dec_stall,
    input  logic [2:0]             dec_consume
);

    localparam int unsigned CntW = $clog2(DEPTH_HW) + 1;
    localparam int unsigned OutW = $clog2(MAX_OUTST + 1);

    logic                   flushAll;
    logic [ADDR_WIDTH-1:0]  target;
    logic [ADDR_WIDTH-1:0]  headPcQ, headPcD;
    logic [ADDR_WIDTH-1:0]  fetchAddrQ, fetchAddrD;
    logic [OutW-1:0]        outstQ, outstD;
    logic [OutW-1:0]        dropQ, dropD;
    logic [1:0]             skipQ, skipD;
    logic [CntW-1:0]        count;
    logic [INSTR_WIDTH-1:0] window;
    logic                   reqFire, respKeep, doConsume;
    logic [2:0]             consumeAmt, ringConsume;
    logic                   unusedBits;

    assign flushAll   = rst | flush;
    assign target     = rst ? RESET_PC : flush_pc;
    assign unusedBits = target[0];

    // Space for every in-flight word is reserved up front, so responses can never overflow.
    assign fetch_req_valid = !flushAll && (outstQ < OutW'(MAX_OUTST)) &&
                             ((int'(count) + 4 * (int'(outstQ) + 1)) <= int'(DEPTH_HW));
    assign reqFire     = fetch_req_valid & fetch_req_ready;
    assign respKeep    = resp_valid & ~flushAll & (dropQ == '0);
    assign consumeAmt  = (dec_consume > 3'd4) ? 3'd4 : dec_consume;
    assign doConsume   = out_valid & ~dec_stall & ~flushAll;
    assign ringConsume = doConsume ? consumeAmt : 3'd0;

    assign out_valid  = count >= CntW'(4);
    assign out_instr  = out_valid ? window : NOP_WINDOW;
    assign out_pc     = headPcQ;
    assign fetch_addr = fetchAddrQ;

    always_comb begin
        headPcD    = headPcQ;
        fetchAddrD = fetchAddrQ;
        outstD     = outstQ;
        dropD      = dropQ;
        skipD      = skipQ;
        if (flushAll) begin
            headPcD    = target;
            fetchAddrD = {target[31:3], 3'b000};
            skipD      = target[2:1];
            // Pending drops are already part of outstQ; everything still in flight becomes stale.
            dropD      = (resp_valid && outstQ != '0) ? outstQ - OutW'(1) : outstQ;
            outstD     = dropD;
        end else begin
            if (reqFire) fetchAddrD = fetchAddrQ + 32'd8;
            outstD = outstQ + OutW'(reqFire) - OutW'(resp_valid);
            if (resp_valid && dropQ != '0) dropD = dropQ - OutW'(1);
            if (respKeep) skipD = 2'b00;
            if (doConsume) headPcD = headPcQ + {28'b0, consumeAmt, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            headPcQ    <= RESET_PC;
            fetchAddrQ <= {RESET_PC[31:3], 3'b000};
            skipQ      <= RESET_PC[2:1];
            outstQ     <= dropD;
            dropQ      <= dropD;
        end else begin
            headPcQ    <= headPcD;
            fetchAddrQ <= fetchAddrD;
            skipQ      <= skipD;
            outstQ     <= outstD;
            dropQ      <= dropD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && out_valid && !dec_stall) begin
            assert (dec_consume <= 3'd4);
        end
    end

    hw_ring_buffer #(
        .DEPTH_HW (DEPTH_HW)
    ) u_ring (
        .clk     (clk),
        .clear   (flushAll),
        .wrEn    (respKeep),
        .wrData  (resp_data),
        .wrSkip  (skipQ),
        .consume (ringConsume),
        .count   (count),
        .window  (window)
    );

endmodule

// File: tb/tb_instr_align_buffer.sv
// Directed bench: in-order latency memory model plus a PC scoreboard of expected windows.
module tb_instr_align_buffer;
    import instr_align_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, fetch_req_valid, fetch_req_ready, resp_valid;
    logic        out_valid, dec_stall;
    logic [31:0] flush_pc, fetch_addr, out_pc;
    logic [63:0] resp_data, out_instr;
    logic [2:0]  dec_consume;

    instr_align_buffer #(
        .DEPTH_HW  (16),
        .MAX_OUTST (2),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_addr      (fetch_addr),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .dec_stall       (dec_stall),
        .dec_consume     (dec_consume)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] WORD0 = 64'h57c157c1_00000013;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] qAddr[$];
    int          qDue[$];
    logic [31:0] expQ[$];
    logic [31:0] modelPc;

    function automatic logic [15:0] hwAt(input logic [31:0] a);
        logic [63:0] w0;
        w0 = WORD0;
        if (a < 32'd8) return w0[a[2:1]*16 +: 16];
        return {4'hC, a[11:0]};
    endfunction

    function automatic logic [63:0] windowAt(input logic [31:0] p);
        return {hwAt(p + 32'd6), hwAt(p + 32'd4), hwAt(p + 32'd2), hwAt(p)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record handshake before the edge, then present the memory response for the new cycle.
    task automatic cycle();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = fetch_req_valid && fetch_req_ready;
        a  = fetch_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            qAddr.push_back(a);
            qDue.push_back(cyc - 1 + lat);
        end
        resp_valid = 1'b0;
        resp_data  = '0;
        if (qAddr.size() > 0 && qDue[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = windowAt(qAddr.pop_front());
            void'(qDue.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic consumeHw(input int n);
        dec_stall   = 1'b0;
        dec_consume = 3'(n);
        modelPc     = modelPc + 32'(2 * n);
        expQ.push_back(modelPc);
        cycle();
        dec_consume = 3'd0;
    endtask

    task automatic checkWindow(input string tag);
        logic [31:0] p;
        for (int i = 0; i < 40 && !out_valid; i++) cycle();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        p = (expQ.size() > 0) ? expQ.pop_front() : 32'hFFFF_FFFF;
        chk({tag, "_pc"}, 64'(out_pc), 64'(p));
        chk({tag, "_instr"}, out_instr, windowAt(p));
    endtask

    task automatic driveToTwo();
        for (int i = 0; i < 40 && qAddr.size() != 2; i++) begin
            if (out_valid) consumeHw(4);
            else cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = '0; fetch_req_ready = 1'b1;
        resp_valid = 1'b0; resp_data = '0; dec_stall = 1'b0; dec_consume = 3'd0;
        modelPc = 32'h0;
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", out_instr, 64'h00000013_00000013);
        chk("rst_pc", 64'(out_pc), 64'h0);
        chk("rst_faddr", 64'(fetch_addr), 64'h0);
        chk("rst_freq", 64'(fetch_req_valid), 64'd1);
        expQ.push_back(32'h0);

        // Latency 1: request at cycle 1, response at 2, window at 3.
        cycle();
        chk("c2_valid", 64'(out_valid), 64'd0);
        chk("c2_faddr", 64'(fetch_addr), 64'h8);
        cycle();
        chk("c3_valid", 64'(out_valid), 64'd1);
        checkWindow("w0");
        chk("w0_literal", out_instr, 64'h57c157c1_00000013);

        consumeHw(2);
        checkWindow("pc4");
        consumeHw(1);
        checkWindow("pc6");
        chk("straddle", {32'h0, out_instr[31:0]}, 64'h0000_0000_c008_57c1);
        consumeHw(1);
        checkWindow("pc8");

        // Stall until the ring is full and fetch stops.
        dec_stall = 1'b1;
        repeat (10) cycle();
        chk("full_freq", 64'(fetch_req_valid), 64'd0);
        chk("full_faddr", 64'(fetch_addr), 64'(modelPc + 32'd32));
        expQ.push_back(modelPc);
        checkWindow("full_hold");
        consumeHw(4);
        chk("rel_freq", 64'(fetch_req_valid), 64'd1);
        chk("rel_faddr", 64'(fetch_addr), 64'h28);
        checkWindow("rel");

        // Shift head to 10, then consume 4 per step so the window crosses the ring end.
        consumeHw(2);
        checkWindow("prewrap");
        for (int i = 0; i < 8; i++) begin
            consumeHw(4);
            checkWindow("wrap");
        end

        // Redirect with two requests in flight.
        lat = 4;
        driveToTwo();
        chk("preflush_outst", 64'(qAddr.size()), 64'd2);
        flush = 1'b1;
        flush_pc = 32'h0000_0106;
        expQ.delete();
        modelPc = 32'h0000_0106;
        expQ.push_back(modelPc);
        cycle();
        flush = 1'b0;
        #1;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_faddr", 64'(fetch_addr), 64'h100);
        chk("fl_pc", 64'(out_pc), 64'h106);
        checkWindow("flush");
        consumeHw(3);
        checkWindow("flush_c3");

        // Reset with requests in flight.
        driveToTwo();
        chk("prerst_outst", 64'(qAddr.size()), 64'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        expQ.delete();
        modelPc = 32'h0;
        expQ.push_back(modelPc);
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_instr", out_instr, 64'h00000013_00000013);
        chk("rs_pc", 64'(out_pc), 64'h0);
        chk("rs_faddr", 64'(fetch_addr), 64'h0);
        checkWindow("post_rst");
        consumeHw(2);
        checkWindow("post_rst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
